// File: rtl/alu_issue_ctrl.sv
// Issue controller between a request/response handshake and an external single-cycle ALU.
// Optional statistics counters are enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [5:0]  op_funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_cout,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_flags,
  output logic        rsp_err,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_errs
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  flags_q, flags_d;
  logic        err_q, err_d;

  logic        funct_legal;
  logic [3:0]  funct_code;
  logic        accept;

  always_comb begin
    funct_legal = 1'b1;
    funct_code  = 4'b0000;
    unique case (op_funct)
      6'b100100: funct_code = 4'b0000;
      6'b100101: funct_code = 4'b0001;
      6'b100000: funct_code = 4'b0010;
      6'b100010: funct_code = 4'b0110;
      6'b100111: funct_code = 4'b1100;
      6'b101010: funct_code = 4'b0111;
      default:   funct_legal = 1'b0;
    endcase
  end

  assign accept = (state_q == IDLE) && op_valid;

  // NOTE: every signal assigned below gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (funct_legal) begin
            src1_d  = op_a;
            src2_d  = op_b;
            ctrl_d  = funct_code;
            state_d = ISSUE;
          end else begin
            // Illegal funct skips the ALU entirely; its operand registers keep the prior issue.
            result_d = '0;
            flags_d  = '0;
            err_d    = 1'b1;
            state_d  = RESP;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        result_d = alu_result;
        flags_d  = {alu_overflow, alu_cout, alu_zero};
        err_d    = 1'b0;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      src1_q   <= '0;
      src2_q   <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  assign op_ready   = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign alu_src1   = src1_q;
  assign alu_src2   = src2_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops_q, stat_errs_q;

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q  <= '0;
      stat_errs_q <= '0;
    end else if (accept) begin
      if (funct_legal && (stat_ops_q != 16'hFFFF))
        stat_ops_q <= stat_ops_q + 16'd1;
      if (!funct_legal && (stat_errs_q != 16'hFFFF))
        stat_errs_q <= stat_errs_q + 16'd1;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_errs = stat_errs_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign stat_ops  = '0;
  assign stat_errs = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural single-cycle ALU model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [5:0]  op_funct;
  logic [31:0] op_a, op_b;
  logic [31:0] alu_src1, alu_src2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero, alu_cout, alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic        rsp_err;
  logic [15:0] stat_ops, stat_errs;

  int errors = 0;
  int checks = 0;
  int legal_cnt = 0;
  int illegal_cnt = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_funct(op_funct),
    .op_a(op_a), .op_b(op_b),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .stat_ops(stat_ops), .stat_errs(stat_errs)
  );

  // Behavioural ALU driven by the controller's registered operands.
  logic [32:0] sum;
  always_comb begin
    sum          = '0;
    alu_result   = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_src1 & alu_src2;
      4'b0001: alu_result = alu_src1 | alu_src2;
      4'b1100: alu_result = ~(alu_src1 | alu_src2);
      4'b0010: begin
        sum          = {1'b0, alu_src1} + {1'b0, alu_src2};
        alu_result   = sum[31:0];
        alu_cout     = sum[32];
        alu_overflow = (alu_src1[31] == alu_src2[31]) && (sum[31] != alu_src1[31]);
      end
      4'b0110: begin
        sum          = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
        alu_result   = sum[31:0];
        alu_cout     = sum[32];
        alu_overflow = (alu_src1[31] != alu_src2[31]) && (sum[31] != alu_src1[31]);
      end
      4'b0111: alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single accepting edge.
  task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_funct = f;
    op_a     = a;
    op_b     = b;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic release_rsp(input string name);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (op_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_return: op_ready=%b rsp_valid=%b, required 1 0", name, op_ready, rsp_valid);
    end
  endtask

  task automatic legal_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] exp_ctrl,
                          input logic [31:0] exp_res, input logic [2:0] exp_flags);
    send(f, a, b);
    legal_cnt++;
    checks++;
    if (alu_ctrl !== exp_ctrl || alu_src1 !== a || alu_src2 !== b || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_issue: ctrl=%b src1=%h src2=%h op_ready=%b, required %b %h %h 0",
               name, alu_ctrl, alu_src1, alu_src2, op_ready, exp_ctrl, a, b);
    end
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_early_valid: cycle %0d rsp_valid=%b, required 0", name, c, rsp_valid);
      end
      tick();
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== exp_res || rsp_flags !== exp_flags || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_rsp: valid=%b result=%h flags=%b err=%b, required 1 %h %b 0",
               name, rsp_valid, rsp_result, rsp_flags, rsp_err, exp_res, exp_flags);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (op_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_src1 !== 32'd0 || alu_src2 !== 32'd0 ||
        alu_ctrl !== 4'd0 || rsp_result !== 32'd0 || rsp_flags !== 3'd0 || rsp_err !== 1'b0 ||
        stat_ops !== 16'd0 || stat_errs !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b src1=%h src2=%h ctrl=%b res=%h flags=%b err=%b ops=%0d errs=%0d",
               op_ready, rsp_valid, alu_src1, alu_src2, alu_ctrl, rsp_result, rsp_flags, rsp_err,
               stat_ops, stat_errs);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    legal_op("add", 6'b100000, 32'd5, 32'd3, 4'b0010, 32'd8, 3'b000);
    release_rsp("add");
  endtask

  task automatic test_sub_flags();
    legal_op("sub", 6'b100010, 32'h8000_0000, 32'd1, 4'b0110, 32'h7FFF_FFFF, 3'b110);
    release_rsp("sub");
  endtask

  task automatic test_illegal();
    send(6'b000000, 32'hDEAD_BEEF, 32'h1234_5678);
    illegal_cnt++;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 32'd0 || rsp_flags !== 3'd0) begin
      errors++;
      $display("FAIL illegal_rsp: valid=%b err=%b result=%h flags=%b, required 1 1 0 0",
               rsp_valid, rsp_err, rsp_result, rsp_flags);
    end
    checks++;
    if (alu_ctrl !== 4'b0110 || alu_src1 !== 32'h8000_0000 || alu_src2 !== 32'd1 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL illegal_alu_hold: ctrl=%b src1=%h src2=%h ready=%b, required 0110 80000000 00000001 0",
               alu_ctrl, alu_src1, alu_src2, op_ready);
    end
    release_rsp("illegal");
  endtask

  task automatic test_backpressure();
    legal_op("and_bp", 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 32'hF000_F000, 3'b000);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'hF000_F000 || rsp_flags !== 3'b000 ||
          rsp_err !== 1'b0 || op_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d valid=%b result=%h flags=%b err=%b ready=%b",
                 c, rsp_valid, rsp_result, rsp_flags, rsp_err, op_ready);
      end
    end
    release_rsp("backpressure");
  endtask

  task automatic test_back_to_back();
    legal_op("slt", 6'b101010, 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 3'b000);
    release_rsp("slt");
    legal_op("nor", 6'b100111, 32'hFFFF_0000, 32'h0000_FFFF, 4'b1100, 32'd0, 3'b001);
    release_rsp("nor");
    legal_op("or", 6'b100101, 32'h0000_00F0, 32'h0000_000F, 4'b0001, 32'h0000_00FF, 3'b000);
    release_rsp("or");
  endtask

  task automatic test_reset_in_wait();
    send(6'b100000, 32'd100, 32'd200);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    legal_cnt = 0;
    illegal_cnt = 0;
    checks++;
    if (rsp_valid !== 1'b0 || op_ready !== 1'b1 || alu_src1 !== 32'd0 || alu_src2 !== 32'd0 ||
        alu_ctrl !== 4'd0 || rsp_result !== 32'd0 || rsp_flags !== 3'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_state: valid=%b ready=%b src1=%h src2=%h ctrl=%b res=%h flags=%b err=%b",
               rsp_valid, op_ready, alu_src1, alu_src2, alu_ctrl, rsp_result, rsp_flags, rsp_err);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || op_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_wait_no_rsp: cycle %0d valid=%b ready=%b, required 0 1", c, rsp_valid, op_ready);
      end
    end
  endtask

  task automatic test_stats();
    logic [15:0] exp_ops, exp_errs;
    legal_op("st_add", 6'b100000, 32'd1, 32'd1, 4'b0010, 32'd2, 3'b000);
    release_rsp("st_add");
    send(6'b111111, 32'd0, 32'd0);
    illegal_cnt++;
    release_rsp("st_ill1");
    legal_op("st_and", 6'b100100, 32'd6, 32'd3, 4'b0000, 32'd2, 3'b000);
    release_rsp("st_and");
    send(6'b001000, 32'd0, 32'd0);
    illegal_cnt++;
    release_rsp("st_ill2");
    legal_op("st_sub", 6'b100010, 32'd7, 32'd7, 4'b0110, 32'd0, 3'b011);
    release_rsp("st_sub");
`ifdef ALU_ISSUE_STATS_EN
    exp_ops  = 16'(legal_cnt);
    exp_errs = 16'(illegal_cnt);
`else
    exp_ops  = 16'd0;
    exp_errs = 16'd0;
`endif
    checks++;
    if (stat_ops !== exp_ops || stat_errs !== exp_errs) begin
      errors++;
      $display("FAIL stats: stat_ops=%0d stat_errs=%0d, required %0d %0d", stat_ops, stat_errs, exp_ops, exp_errs);
    end
  endtask

  initial begin
    rst       = 1'b1;
    op_valid  = 1'b0;
    op_funct  = '0;
    op_a      = '0;
    op_b      = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_flags();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_in_wait();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
